// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the DRAM requester arbiter and its round-robin picker.
package dram_arb_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Index width for n requesters; never below one bit so n = 2 still gets a real index.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dram_arb_rr_pick.sv
// Combinational round-robin picker: the first set request after 'last', wrapping around.
module rr_pick
  import dram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic            valid,
  output logic [LW-1:0]   winner
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    valid  = 1'b0;
    winner = '0;
    // Walk from the farthest candidate to the nearest so the nearest one after 'last' wins.
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx[LW-1:0];
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM controller port between NREQ client blocks.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rdata,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_write,
  output logic [DW-1:0]     mem_wdata,
  output logic              mem_ena,
  input  logic              mem_ack,
  input  logic              mem_busy,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int LW = idx_width(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  arb_state_t      state;
  logic [LW-1:0]   last;
  logic [LW-1:0]   cur;
  logic            pick_valid;
  logic [LW-1:0]   pick_idx;

  rr_pick #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_pick (
    .req    (req),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // NOTE: all state below is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= LW'(NREQ - 1);
      cur       <= '0;
      gnt       <= '0;
      done      <= '0;
      mem_ena   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            mem_addr  <= req_addr[int'(pick_idx)*AW +: AW];
            mem_wdata <= req_wdata[int'(pick_idx)*DW +: DW];
            mem_write <= req_we[pick_idx];
            cur       <= pick_idx;
            last      <= pick_idx;
            gnt       <= ONE << pick_idx;
            mem_ena   <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Busy alone is refresh/init; ack alone is left over from the previous access.
          if (mem_busy && mem_ack) begin
            mem_ena <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (!mem_busy) begin
            if (!mem_write) rdata <= mem_rdata;
            done  <= ONE << cur;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a small behavioural DRAM controller model.
module tb_dram_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int DW   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_we = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]   gnt, done;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     mem_addr;
  logic              mem_write;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ena;
  logic              mem_ack = 1'b0;
  logic              mem_busy = 1'b0;
  logic [DW-1:0]     mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  dram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_ena   (mem_ena),
    .mem_ack   (mem_ack),
    .mem_busy  (mem_busy),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Controller model: optional refresh before the access, optional late acceptance,
  // sticky ack cleared on the first idle cycle unless stale_mode keeps it up.
  typedef enum {M_IDLE, M_REFRESH, M_ACCESS} m_state_t;
  m_state_t m_state = M_IDLE;
  int  m_cnt = 0;
  int  m_wait = 0;
  int  acc_len = 3;
  int  refresh_len = 0;
  int  accept_delay = 0;
  bit  stale_mode = 1'b0;

  always @(posedge clk) begin
    case (m_state)
      M_IDLE: begin
        mem_busy <= 1'b0;
        if (!stale_mode) mem_ack <= 1'b0;
        if (mem_ena) begin
          if (m_wait >= accept_delay) begin
            m_wait   <= 0;
            mem_busy <= 1'b1;
            if (refresh_len > 0) begin
              m_state <= M_REFRESH;
              m_cnt   <= refresh_len;
              mem_ack <= 1'b0;
            end else begin
              m_state <= M_ACCESS;
              m_cnt   <= acc_len;
              mem_ack <= 1'b1;
            end
          end else begin
            m_wait <= m_wait + 1;
          end
        end else begin
          m_wait <= 0;
        end
      end
      M_REFRESH: begin
        if (m_cnt == 1) begin
          m_state <= M_ACCESS;
          m_cnt   <= acc_len;
          mem_ack <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      M_ACCESS: begin
        if (m_cnt == 1) begin
          m_state  <= M_IDLE;
          mem_busy <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      default: m_state <= M_IDLE;
    endcase
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_gnt(input int budget, output bit ok, output logic [NREQ-1:0] seen);
    ok = 1'b0;
    seen = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        ok = 1'b1;
        seen = gnt;
        return;
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok, output logic [NREQ-1:0] seen);
    ok = 1'b0;
    seen = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done != '0) begin
        ok = 1'b1;
        seen = done;
        return;
      end
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done got %b want 0000", done); end
    checks++; if (mem_ena !== 1'b0) begin errors++; $display("FAIL reset_ena got %b want 0", mem_ena); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", mem_write); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", mem_addr); end
    checks++; if (mem_wdata !== 4'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
    checks++; if (rdata !== 4'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    bit ok;
    logic [NREQ-1:0] seen;
    int fall_at, done_at;
    bit prev_busy;
    mem_rdata = 4'hA;
    set_req(2, 1'b0, 16'h1234, 4'h0);
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL read_gnt_latency got %b want 0100", gnt); end
    checks++; if (mem_ena !== 1'b1) begin errors++; $display("FAIL read_ena got %b want 1", mem_ena); end
    checks++; if (mem_addr !== 16'h1234) begin errors++; $display("FAIL read_addr got %h want 1234", mem_addr); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL read_write got %b want 0", mem_write); end
    req = '0;
    fall_at = -1;
    done_at = -1;
    prev_busy = mem_busy;
    seen = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (prev_busy && !mem_busy) fall_at = c;
      prev_busy = mem_busy;
      if (done != '0) begin
        done_at = c;
        seen = done;
        break;
      end
    end
    checks++; if (seen !== 4'b0100) begin errors++; $display("FAIL read_done got %b want 0100", seen); end
    checks++; if (fall_at < 0 || done_at !== fall_at + 1) begin errors++; $display("FAIL read_done_latency got %0d want %0d", done_at, fall_at + 1); end
    checks++; if (rdata !== 4'hA) begin errors++; $display("FAIL read_rdata got %h want a", rdata); end
    @(negedge clk);
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL read_done_pulse got %b want 0000", done); end
    wait_done(3, ok, seen);
    checks++; if (ok) begin errors++; $display("FAIL read_extra_done got %b want none", seen); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [NREQ-1:0] g_q [$];
    logic [NREQ-1:0] d_q [$];
    do_reset();
    mem_rdata = 4'h6;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 16'(16'h0100 + i), 4'h0);
    for (int c = 0; c < 400 && d_q.size() < 5; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g_q.push_back(gnt);
        if (g_q.size() == 5) req = '0;
      end
      if (done != '0) d_q.push_back(done);
    end
    repeat (3) begin
      @(negedge clk);
      if (gnt != '0) g_q.push_back(gnt);
      if (done != '0) d_q.push_back(done);
    end
    checks++; if (g_q.size() != 5) begin errors++; $display("FAIL rr_gnt_count got %0d want 5", g_q.size()); end
    checks++; if (d_q.size() != 5) begin errors++; $display("FAIL rr_done_count got %0d want 5", d_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < g_q.size()) begin
        checks++; if (g_q[i] !== exp_order[i]) begin errors++; $display("FAIL rr_gnt_order[%0d] got %b want %b", i, g_q[i], exp_order[i]); end
      end
      if (i < d_q.size()) begin
        checks++; if (d_q[i] !== exp_order[i]) begin errors++; $display("FAIL rr_done_order[%0d] got %b want %b", i, d_q[i], exp_order[i]); end
      end
    end
  endtask

  task automatic test_refresh();
    bit ok;
    logic [NREQ-1:0] seen;
    int refresh_cycles, ena_drops, dones;
    bit accepted, prev_accept, dropped_without_ack;
    mem_rdata = 4'h3;
    refresh_len = 12;
    set_req(3, 1'b0, 16'h0777, 4'h0);
    wait_gnt(20, ok, seen);
    req = '0;
    checks++; if (!ok || seen !== 4'b1000) begin errors++; $display("FAIL refresh_gnt got %b want 1000", seen); end
    refresh_cycles = 0;
    ena_drops = 0;
    dones = 0;
    accepted = 1'b0;
    prev_accept = 1'b0;
    dropped_without_ack = 1'b0;
    for (int c = 0; c < 100 && !accepted; c++) begin
      @(negedge clk);
      if (mem_busy && !mem_ack) begin
        refresh_cycles++;
        if (!mem_ena) ena_drops++;
      end
      if (!mem_ena) begin
        accepted = 1'b1;
        if (!prev_accept) dropped_without_ack = 1'b1;
      end
      if (done != '0) dones++;
      prev_accept = mem_busy && mem_ack;
    end
    refresh_len = 0;
    checks++; if (refresh_cycles != 12) begin errors++; $display("FAIL refresh_cycles got %0d want 12", refresh_cycles); end
    checks++; if (ena_drops != 0) begin errors++; $display("FAIL refresh_ena_held got %0d drops want 0", ena_drops); end
    checks++; if (!accepted || dropped_without_ack) begin errors++; $display("FAIL refresh_accept got accepted=%0b early=%0b want 1 0", accepted, dropped_without_ack); end
    wait_done(50, ok, seen);
    checks++; if (!ok || seen !== 4'b1000 || dones != 0) begin errors++; $display("FAIL refresh_done got %b (early %0d) want 1000", seen, dones); end
    checks++; if (rdata !== 4'h3) begin errors++; $display("FAIL refresh_rdata got %h want 3", rdata); end
    wait_done(5, ok, seen);
    checks++; if (ok) begin errors++; $display("FAIL refresh_extra_done got %b want none", seen); end
  endtask

  task automatic test_stale_ack();
    bit ok;
    logic [NREQ-1:0] seen;
    int stale_cycles, early_done, early_drop;
    bit accepted, prev_accept;
    stale_mode = 1'b1;
    accept_delay = 5;
    mem_rdata = 4'h8;
    set_req(1, 1'b0, 16'h0042, 4'h0);
    wait_gnt(20, ok, seen);
    req = '0;
    wait_done(100, ok, seen);
    checks++; if (!ok || seen !== 4'b0010) begin errors++; $display("FAIL stale_first_done got %b want 0010", seen); end
    mem_rdata = 4'hC;
    set_req(0, 1'b0, 16'h0043, 4'h0);
    wait_gnt(20, ok, seen);
    req = '0;
    checks++; if (!ok || seen !== 4'b0001) begin errors++; $display("FAIL stale_gnt got %b want 0001", seen); end
    stale_cycles = 0;
    early_done = 0;
    early_drop = 0;
    accepted = 1'b0;
    prev_accept = mem_busy && mem_ack;
    for (int c = 0; c < 100 && !accepted; c++) begin
      @(negedge clk);
      if (!mem_busy && mem_ack && mem_ena) stale_cycles++;
      if (!mem_ena) begin
        accepted = 1'b1;
        if (!prev_accept) early_drop++;
      end
      if (done != '0) early_done++;
      prev_accept = mem_busy && mem_ack;
    end
    stale_mode = 1'b0;
    accept_delay = 0;
    checks++; if (stale_cycles < 1) begin errors++; $display("FAIL stale_window got %0d cycles want >0", stale_cycles); end
    checks++; if (early_drop != 0 || !accepted) begin errors++; $display("FAIL stale_accept got early=%0d accepted=%0b want 0 1", early_drop, accepted); end
    checks++; if (early_done != 0) begin errors++; $display("FAIL stale_early_done got %0d want 0", early_done); end
    wait_done(100, ok, seen);
    checks++; if (!ok || seen !== 4'b0001) begin errors++; $display("FAIL stale_done got %b want 0001", seen); end
    checks++; if (rdata !== 4'hC) begin errors++; $display("FAIL stale_rdata got %h want c", rdata); end
  endtask

  task automatic test_write();
    bit ok, got_done;
    logic [NREQ-1:0] seen;
    int unstable;
    mem_rdata = 4'h7;
    repeat (2) @(negedge clk);
    set_req(1, 1'b1, 16'hFFFF, 4'h5);
    wait_gnt(20, ok, seen);
    req = '0;
    req_we = '0;
    req_wdata = '0;
    req_addr = '0;
    checks++; if (!ok || seen !== 4'b0010) begin errors++; $display("FAIL write_gnt got %b want 0010", seen); end
    unstable = 0;
    got_done = 1'b0;
    seen = '0;
    for (int c = 0; c < 100 && !got_done; c++) begin
      if (mem_write !== 1'b1 || mem_wdata !== 4'h5 || mem_addr !== 16'hFFFF) unstable++;
      @(negedge clk);
      if (done != '0) begin
        got_done = 1'b1;
        seen = done;
        if (mem_write !== 1'b1 || mem_wdata !== 4'h5 || mem_addr !== 16'hFFFF) unstable++;
      end
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL write_cmd_stable got %0d bad cycles want 0", unstable); end
    checks++; if (!got_done || seen !== 4'b0010) begin errors++; $display("FAIL write_done got %b want 0010", seen); end
    checks++; if (rdata !== 4'hC) begin errors++; $display("FAIL write_rdata_kept got %h want c", rdata); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    logic [NREQ-1:0] seen;
    int stray;
    acc_len = 8;
    mem_rdata = 4'h2;
    set_req(2, 1'b0, 16'h0BAD, 4'h0);
    wait_gnt(20, ok, seen);
    req = '0;
    for (int c = 0; c < 50 && mem_ena; c++) @(negedge clk);
    @(negedge clk);
    checks++; if (mem_busy !== 1'b1 || done !== 4'b0000) begin errors++; $display("FAIL midwait_setup got busy=%b done=%b want 1 0000", mem_busy, done); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (mem_ena !== 1'b0 || gnt !== 4'b0000 || done !== 4'b0000) begin errors++; $display("FAIL midwait_reset got ena=%b gnt=%b done=%b want 0 0000 0000", mem_ena, gnt, done); end
    checks++; if (rdata !== 4'h0) begin errors++; $display("FAIL midwait_rdata got %h want 0", rdata); end
    stray = 0;
    for (int c = 0; c < 50 && mem_busy; c++) begin
      @(negedge clk);
      if (done != '0 || gnt != '0) stray++;
    end
    repeat (3) begin
      @(negedge clk);
      if (done != '0 || gnt != '0) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL midwait_no_report got %0d pulses want 0", stray); end
    acc_len = 3;
    mem_rdata = 4'h9;
    set_req(0, 1'b0, 16'h0010, 4'h0);
    set_req(2, 1'b0, 16'h0020, 4'h0);
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL midwait_priority got %b want 0001", gnt); end
    checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL midwait_addr got %h want 0010", mem_addr); end
    req = '0;
    wait_done(50, ok, seen);
    checks++; if (!ok || seen !== 4'b0001) begin errors++; $display("FAIL midwait_done got %b want 0001", seen); end
    checks++; if (rdata !== 4'h9) begin errors++; $display("FAIL midwait_rdata_after got %h want 9", rdata); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_refresh();
    test_stale_ack();
    test_write();
    test_reset_mid_wait();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Round-robin arbiter that shares one 64K×4 DRAM controller between `NREQ` requesters. It sits between client blocks (video fetch, CPU, test pattern) and the DRAM controller's `addr/write/ena/ack/busy/rd_data` port. For each request it latches the command, holds `ena` until the controller accepts, waits out the access, and returns read data with a one-cycle `done` pulse to the winning requester. Refresh preemption by the controller is absorbed transparently.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `AW`, 16: DRAM address width.
- `DW`, 4: DRAM data width.

Ports:
- `clk`  in  1  system clock. One clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  NREQ  request per requester. Held high until the matching `gnt` bit pulses.
- `req_we`  in  NREQ  1 = write, 0 = read. Sampled with `req`.
- `req_addr`  in  NREQ*AW  packed addresses. Requester i uses `[i*AW +: AW]`.
- `req_wdata`  in  NREQ*DW  packed write data, same packing.
- `gnt`  out  NREQ  one-hot pulse, 1 cycle, when the command is latched. The requester may then drop or change `req`.
- `done`  out  NREQ  one-hot pulse, 1 cycle, when the access is complete.
- `rdata`  out  DW  read data. Valid in the `done` cycle and held until the next `done`.
- `mem_addr`  out  AW  to controller `addr`.
- `mem_write`  out  1  to controller `write`.
- `mem_wdata`  out  DW  to the DRAM data-bus tri-state driver.
- `mem_ena`  out  1  to controller `ena`.
- `mem_ack`  in  1  controller `ack`. Registered and sticky: it stays high until the controller's first IDLE cycle after the access.
- `mem_busy`  in  1  controller `busy`. High whenever the controller is not idle, including during refresh and power-up init.
- `mem_rdata`  in  DW  controller `rd_data`. Stable once `mem_busy` falls.

## Operation
FSM states: `IDLE`, `ISSUE`, `WAIT`, `DONE`.
- **IDLE**
  - If any `req` bit is set, pick the winner round-robin, starting at `(last+1) mod NREQ`.
  - Latch `mem_addr`, `mem_write` and `mem_wdata` from the winner's slice; set `cur = winner`.
  - Pulse `gnt[winner]`, update `last = winner`, set `mem_ena = 1`, and go to ISSUE.
- **ISSUE**
  - Keep `mem_ena = 1`.
  - The command counts as accepted only when `mem_busy = 1` and `mem_ack = 1` in the same cycle.
  - Once accepted: `mem_ena <= 0`, go to WAIT.
  - `mem_busy = 1` with `mem_ack = 0` means refresh or init is in progress: keep asserting.
  - `mem_busy = 0` with `mem_ack = 1` is a stale ack from the previous access: ignore it.
- **WAIT**
  - On `mem_busy = 0`: capture `rdata <= mem_rdata` (reads only; writes leave `rdata` unchanged) and go to DONE.
- **DONE**
  - Pulse `done[cur]` and return to IDLE.
  - Arbitration resumes in the next cycle, so there is one idle cycle between accesses.
- `mem_addr`, `mem_write` and `mem_wdata` are stable from the grant until the exit from DONE.
- Reset values:
  - state IDLE.
  - `gnt`, `done`, `mem_ena`, `mem_write` all 0.
  - `mem_addr`, `mem_wdata`, `rdata` all 0.
  - `last = NREQ-1`, so requester 0 wins first after reset.
- Reset mid-access:
  - The arbiter drops `mem_ena` immediately. The in-flight access completes in the controller unreported; no `done` is issued.
  - The next ISSUE is safe because of the acceptance rule above.
- Ties: only one grant per arbitration. Requesters that lose keep `req` high and are served in round-robin order, so each waits at most NREQ-1 accesses plus any refresh time.
- All outputs are registered. No combinational path from `req`, `mem_ack` or `mem_busy` to any output.

## Timing
- Grant latency: 1 cycle, from `req` high in IDLE to `gnt`/`mem_ena` high.
- `mem_ena` high for at least 2 cycles when the controller is idle: the grant cycle plus the ack cycle.
- Done latency: the controller's access time, plus 1 cycle after `mem_busy` falls.
- With an idle controller the back-to-back period is the access time + 3 cycles.
- A refresh pending at issue adds the refresh duration to ISSUE.
- `mem_busy` high at reset release (controller init, ~10000 cycles): the arbiter may grant and then stall in ISSUE.

## Structure
- Package `dram_arb_pkg` holds:
  - the state enum `arb_state_t` (`IDLE`, `ISSUE`, `WAIT`, `DONE`);
  - the default `AW`/`DW` localparams.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs `req[NREQ]` and `last`; outputs `valid` and `winner` index. It is reused by the other shared-resource blocks in the codebase.

## Test plan
- **Single read.** Controller model holds `rd_data = 4'hA`; `req[2]=1`, `we=0`, `addr=16'h1234` → `gnt[2]` at +1, `mem_addr = 16'h1234`, `done[2]` one cycle after `mem_busy` falls, `rdata = 4'hA`.
- **Round-robin fairness.** `req = 4'b1111` held continuously → grant order 0, 1, 2, 3, 0, with exactly one `gnt` and one `done` per access.
- **Refresh preemption.** Model enters refresh when `ena` rises: `busy = 1`, `ack = 0` for 12 cycles → `mem_ena` stays high throughout; acceptance only when `ack = 1`; one `done`.
- **Stale ack.** Issue immediately after a completed access, with `mem_ack` still 1 and `mem_busy = 0` → the arbiter stays in ISSUE until `busy = 1` and `ack = 1`, with no premature `done`.
- **Write path.** `req[1]` write, `addr = 16'hFFFF`, `wdata = 4'h5` → `mem_write = 1` and `mem_wdata = 4'h5` held until `done[1]`; `rdata` unchanged.
- **Reset mid-WAIT.** `rst` for 1 cycle → next cycle `mem_ena`, `gnt`, `done` = 0 and state IDLE; the following request completes normally with `gnt[0]` priority.
